// File: rtl/legv8_dmem_ctrl.sv
// legv8_dmem_ctrl: LEGv8 data-memory controller with request/response handshake,
// programmable wait states, sized loads/stores with extension, and fault reporting.
// Optional build macro DMEM_STATS_EN adds load/store/fault counters readable at STATS_ADDR.
module legv8_dmem_ctrl #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH       = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_1001_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [63:0] STATS_ADDR  = 64'h0000_0000_FFFF_0000
) (
  input  logic                  iCLK,
  input  logic                  iRSTn,
  input  logic                  iReq,
  input  logic                  iWrite,
  input  logic [1:0]            iSize,
  input  logic                  iSignExt,
  input  logic [63:0]           iAddress,
  input  logic [DATA_WIDTH-1:0] iWriteData,
  output logic                  oReady,
  output logic                  oValid,
  output logic [DATA_WIDTH-1:0] oReadData,
  output logic [1:0]            oFault
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [64:0] REGION_LO = 65'(BASE_ADDR);
  localparam logic [64:0] REGION_HI = 65'(BASE_ADDR) + 65'(DEPTH) * 65'(LANES) - 65'd1;
  localparam logic [1:0]  FAULT_OK    = 2'd0;
  localparam logic [1:0]  FAULT_ALIGN = 2'd1;
  localparam logic [1:0]  FAULT_RANGE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ready_q, valid_q;
  logic [DATA_WIDTH-1:0]   rdata_q, load_q;
  logic [1:0]              fault_out_q;
  logic                    write_q, sext_q, stats_q;
  logic [1:0]              size_q, fault_q;
  logic [63:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    accept_c, misalign_c, out_of_range_c, stats_hit_c;
  logic [64:0]             last_byte_c;
  logic [1:0]              fault_d;
  logic [IDX_W-1:0]        idx_c;
  logic [OFF_W-1:0]        off_c;
  logic [DATA_WIDTH-1:0]   rd_word_c, rd_shift_c, ext_c, load_c, wr_data_c;
  logic [LANES-1:0]        be_base_c, be_c;
  logic                    mem_we_c;

  assign oReady    = ready_q;
  assign oValid    = valid_q;
  assign oReadData = rdata_q;
  assign oFault    = fault_out_q;

  assign accept_c = iReq && ready_q && (state_q == S_IDLE);

  // Classify the incoming request: alignment beats range, stats window overrides both.
  always_comb begin
    misalign_c = 1'b0;
    case (iSize)
      2'd0:    misalign_c = 1'b0;
      2'd1:    misalign_c = iAddress[0];
      2'd2:    misalign_c = |iAddress[1:0];
      default: misalign_c = |iAddress[2:0];
    endcase
    last_byte_c    = {1'b0, iAddress} + ((65'd1 << iSize) - 65'd1);
    out_of_range_c = ({1'b0, iAddress} < REGION_LO) || (last_byte_c > REGION_HI);
    stats_hit_c    = (iAddress == STATS_ADDR) || (iAddress == STATS_ADDR + 64'd8) ||
                     (iAddress == STATS_ADDR + 64'd16);
    if (misalign_c)          fault_d = FAULT_ALIGN;
    else if (out_of_range_c) fault_d = FAULT_RANGE;
    else                     fault_d = FAULT_OK;
`ifdef DMEM_STATS_EN
    if (stats_hit_c) fault_d = (iSize == 2'd3) ? FAULT_OK : FAULT_ALIGN;
`else
    if (stats_hit_c) fault_d = FAULT_RANGE;
`endif
  end

  // Array addressing, lane selection and load extension for the latched request.
  always_comb begin
    idx_c      = IDX_W'((addr_q - BASE_ADDR) >> OFF_W);
    off_c      = addr_q[OFF_W-1:0];
    rd_word_c  = mem_q[idx_c];
    rd_shift_c = rd_word_c >> {off_c, 3'b000};
    case (size_q)
      2'd0:    ext_c = {{(DATA_WIDTH-8){sext_q & rd_shift_c[7]}}, rd_shift_c[7:0]};
      2'd1:    ext_c = {{(DATA_WIDTH-16){sext_q & rd_shift_c[15]}}, rd_shift_c[15:0]};
      2'd2:    ext_c = {{(DATA_WIDTH-32){sext_q & rd_shift_c[31]}}, rd_shift_c[31:0]};
      default: ext_c = rd_shift_c;
    endcase
    case (size_q)
      2'd0:    be_base_c = LANES'(32'h01);
      2'd1:    be_base_c = LANES'(32'h03);
      2'd2:    be_base_c = LANES'(32'h0F);
      default: be_base_c = '1;
    endcase
    be_c      = be_base_c << off_c;
    wr_data_c = wdata_q << {off_c, 3'b000};
    mem_we_c  = (state_q == S_ACCESS) && write_q && !stats_q;
  end

`ifdef DMEM_STATS_EN
  logic [31:0] stat_cnt_q [3];
  logic [1:0]  stat_sel_q;
  logic [1:0]  kind_c;

  assign kind_c = (fault_q != FAULT_OK) ? 2'd2 : (write_q ? 2'd1 : 2'd0);
  assign load_c = stats_q ? DATA_WIDTH'(stat_cnt_q[stat_sel_q]) : ext_c;

  // Saturating transaction counters; a store into the window clears the addressed counter.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int i = 0; i < 3; i++) stat_cnt_q[i] <= '0;
      stat_sel_q <= '0;
    end else begin
      if (accept_c) stat_sel_q <= 2'((iAddress - STATS_ADDR) >> 3);
      if (state_q == S_ACCESS && stats_q && write_q) stat_cnt_q[stat_sel_q] <= '0;
      if (state_q == S_RESP && stat_cnt_q[kind_c] != '1)
        stat_cnt_q[kind_c] <= stat_cnt_q[kind_c] + 32'd1;
    end
  end
`else
  assign load_c = ext_c;
`endif

  // Byte-enable array write; contents survive reset.
  always_ff @(posedge iCLK) begin
    if (mem_we_c) begin
      for (int i = 0; i < LANES; i++)
        if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
    end
  end

  // Request sequencing with registered handshake and response outputs.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      fault_out_q <= FAULT_OK;
      load_q      <= '0;
      write_q     <= 1'b0;
      sext_q      <= 1'b0;
      stats_q     <= 1'b0;
      size_q      <= '0;
      fault_q     <= FAULT_OK;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      fault_out_q <= FAULT_OK;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            write_q <= iWrite;
            size_q  <= iSize;
            sext_q  <= iSignExt;
            addr_q  <= iAddress;
            wdata_q <= iWriteData;
            fault_q <= fault_d;
`ifdef DMEM_STATS_EN
            stats_q <= stats_hit_c;
`else
            stats_q <= 1'b0;
`endif
            ready_q <= 1'b0;
            if (fault_d != FAULT_OK) begin
              state_q <= S_RESP;
            end else if (WAIT_STATES == 0) begin
              state_q <= S_ACCESS;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_W'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_ACCESS;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        S_ACCESS: begin
          load_q  <= write_q ? '0 : load_c;
          state_q <= S_RESP;
        end
        default: begin
          valid_q     <= 1'b1;
          rdata_q     <= (write_q || fault_q != FAULT_OK) ? '0 : load_q;
          fault_out_q <= fault_q;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_dmem_ctrl.sv
// Scoreboard bench for legv8_dmem_ctrl: one instance with no wait states, one with three.
module tb_legv8_dmem_ctrl;

  localparam logic [63:0] B     = 64'h0000_0000_1001_0000;
  localparam logic [63:0] S     = 64'h0000_0000_FFFF_0000;
  localparam logic [63:0] END_A = B + 64'd8192;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  fault;
    logic [31:0] cyc;
    logic [31:0] id;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, req, wr, sext, ready, valid;
  logic [1:0]  size  [2];
  logic [63:0] addr  [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];
  logic [1:0]  fault [2];

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;
  int next_id = 0;
  int unsigned cyc = 0;
  int m_loads = 0, m_stores = 0, m_faults = 0;

  legv8_dmem_ctrl #(.WAIT_STATES(0)) u0 (
    .iCLK(clk), .iRSTn(rst_n[0]), .iReq(req[0]), .iWrite(wr[0]), .iSize(size[0]),
    .iSignExt(sext[0]), .iAddress(addr[0]), .iWriteData(wdata[0]),
    .oReady(ready[0]), .oValid(valid[0]), .oReadData(rdata[0]), .oFault(fault[0]));

  legv8_dmem_ctrl #(.WAIT_STATES(3)) u3 (
    .iCLK(clk), .iRSTn(rst_n[1]), .iReq(req[1]), .iWrite(wr[1]), .iSize(size[1]),
    .iSignExt(sext[1]), .iAddress(addr[1]), .iWriteData(wdata[1]),
    .oReady(ready[1]), .oValid(valid[1]), .oReadData(rdata[1]), .oFault(fault[1]));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endfunction

  function automatic void check_resp(input int u, input exp_t e);
    checks++;
    if (rdata[u] !== e.data || fault[u] !== e.fault || cyc !== e.cyc) begin
      errors++;
      $display("FAIL resp u%0d id=%0d data=%h/%h fault=%0d/%0d cycle=%0d/%0d (actual/required)",
               u, e.id, rdata[u], e.data, fault[u], e.fault, cyc, e.cyc);
    end
  endfunction

  // Monitor: pop and compare on every response pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid[0]) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp u0 unexpected valid data=%h fault=%0d", rdata[0], fault[0]);
      end else begin
        e = q0.pop_front();
        check_resp(0, e);
      end
    end
    if (valid[1]) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp u1 unexpected valid data=%h fault=%0d", rdata[1], fault[1]);
      end else begin
        e = q1.pop_front();
        check_resp(1, e);
      end
    end
  end

  task automatic issue(input int u, input logic w, input logic [1:0] sz, input logic se,
                       input logic [63:0] a, input logic [63:0] d, input logic [63:0] exp_d,
                       input logic [1:0] exp_f, input bit expect_resp);
    int t;
    int lat;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!ready[u] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready[u]) begin
      checks++; errors++;
      $display("FAIL ready_timeout u%0d id=%0d actual=0 required=1", u, next_id);
      return;
    end
    req[u] = 1'b1; wr[u] = w; size[u] = sz; sext[u] = se; addr[u] = a; wdata[u] = d;
    lat = (exp_f != 2'd0) ? 1 : ((u == 1) ? 3 : 0) + 2;
    if (expect_resp) begin
      e.data = exp_d; e.fault = exp_f; e.cyc = 32'(cyc + 1 + lat); e.id = 32'(next_id);
      if (u == 0) begin
        q0.push_back(e);
        if (exp_f != 2'd0) m_faults++;
        else if (w)        m_stores++;
        else               m_loads++;
      end else begin
        q1.push_back(e);
      end
    end
    next_id++;
    @(negedge clk);
    req[u] = 1'b0;
  endtask

  task automatic st(input int u, input logic [1:0] sz, input logic [63:0] a,
                    input logic [63:0] d, input logic [1:0] f);
    issue(u, 1'b1, sz, 1'b0, a, d, 64'd0, f, 1'b1);
  endtask

  task automatic ld(input int u, input logic [1:0] sz, input logic se, input logic [63:0] a,
                    input logic [63:0] exp_d, input logic [1:0] f);
    issue(u, 1'b0, sz, se, a, 64'd0, exp_d, f, 1'b1);
  endtask

  initial begin
    int c;
    rst_n = 2'b00; req = 2'b00; wr = 2'b00; sext = 2'b00;
    for (int i = 0; i < 2; i++) begin
      size[i] = 2'd0; addr[i] = 64'd0; wdata[i] = 64'd0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready[0]), 64'd1);
    chk("reset_valid", 64'(valid[0]), 64'd0);
    chk("reset_rdata", rdata[0], 64'd0);
    chk("reset_fault", 64'(fault[0]), 64'd0);
    chk("reset_ready_ws3", 64'(ready[1]), 64'd1);
    rst_n = 2'b11;

    // Zero-wait instance: basic store/load, sized access, faults, boundaries.
    st(0, 2'd3, B, 64'h1122334455667788, 2'd0);
    ld(0, 2'd3, 1'b0, B, 64'h1122334455667788, 2'd0);
    st(0, 2'd0, B + 3, 64'h00000000000000F0, 2'd0);
    ld(0, 2'd0, 1'b1, B + 3, 64'hFFFFFFFFFFFFFFF0, 2'd0);
    ld(0, 2'd0, 1'b0, B + 3, 64'h00000000000000F0, 2'd0);
    ld(0, 2'd0, 1'b0, B + 4, 64'h0000000000000044, 2'd0);
    ld(0, 2'd2, 1'b0, B + 2, 64'd0, 2'd1);
    ld(0, 2'd3, 1'b0, B, 64'h11223344F0667788, 2'd0);
    ld(0, 2'd3, 1'b0, END_A, 64'd0, 2'd2);
    ld(0, 2'd3, 1'b0, B - 8, 64'd0, 2'd2);
    st(0, 2'd3, END_A, 64'hDEADBEEFDEADBEEF, 2'd2);
    st(0, 2'd0, B - 1, 64'h00000000000000AB, 2'd2);
    ld(0, 2'd3, 1'b0, B, 64'h11223344F0667788, 2'd0);
    st(0, 2'd3, B + 8, 64'd0, 2'd0);
    st(0, 2'd1, B + 14, 64'h000000000000BEEF, 2'd0);
    st(0, 2'd0, B + 9, 64'hFFFFFFFFFFFFFF5A, 2'd0);
    ld(0, 2'd1, 1'b1, B + 14, 64'hFFFFFFFFFFFFBEEF, 2'd0);
    ld(0, 2'd2, 1'b1, B + 12, 64'hFFFFFFFFBEEF0000, 2'd0);
    ld(0, 2'd2, 1'b0, B + 12, 64'h00000000BEEF0000, 2'd0);
    ld(0, 2'd1, 1'b0, B + 8, 64'h0000000000005A00, 2'd0);
    ld(0, 2'd3, 1'b0, B + 8, 64'hBEEF000000005A00, 2'd0);
    st(0, 2'd3, END_A - 8, 64'hA5A50102_0304C3C3, 2'd0);
    ld(0, 2'd0, 1'b1, END_A - 1, 64'hFFFFFFFFFFFFFFA5, 2'd0);
    ld(0, 2'd1, 1'b0, END_A - 1, 64'd0, 2'd1);
    ld(0, 2'd2, 1'b0, END_A - 4, 64'h00000000A5A50102, 2'd0);
    ld(0, 2'd0, 1'b0, END_A, 64'd0, 2'd2);
`ifdef DMEM_STATS_EN
    ld(0, 2'd3, 1'b0, S, 64'(m_loads), 2'd0);
    ld(0, 2'd3, 1'b0, S + 8, 64'(m_stores), 2'd0);
    ld(0, 2'd3, 1'b0, S + 16, 64'(m_faults), 2'd0);
    ld(0, 2'd2, 1'b0, S, 64'd0, 2'd1);
    m_loads = 0;
    st(0, 2'd3, S, 64'd0, 2'd0);
    ld(0, 2'd3, 1'b0, S, 64'(m_loads), 2'd0);
`else
    ld(0, 2'd3, 1'b0, S, 64'd0, 2'd2);
`endif

    // Three-wait instance: latency, ready window, fault shortcut, abort by reset.
    st(1, 2'd3, B, 64'h0102030405060708, 2'd0);
    ld(1, 2'd3, 1'b0, B, 64'h0102030405060708, 2'd0);
    c = 0;
    while (!ready[1] && c < 50) begin
      c++;
      @(negedge clk);
    end
    chk("ws3_ready_low_cycles", 64'(c), 64'd5);
    ld(1, 2'd2, 1'b0, B + 2, 64'd0, 2'd1);
    issue(1, 1'b1, 2'd3, 1'b0, B, 64'hDEADDEADDEADDEAD, 64'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    chk("abort_ready", 64'(ready[1]), 64'd1);
    chk("abort_valid", 64'(valid[1]), 64'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (10) @(negedge clk);
    ld(1, 2'd3, 1'b0, B, 64'h0102030405060708, 2'd0);

    c = 0;
    while ((q0.size() != 0 || q1.size() != 0) && c < 200) begin
      c++;
      @(negedge clk);
    end
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
